// File: rtl/key_sw_device_pkg.sv
// Shared constants and helpers for the KEY/SW memory-mapped device.
// Control/status register layout used by both input paths.
package key_sw_device_pkg;

  localparam logic [31:0] ADDR_KDATA = 32'hFFFFF080;
  localparam logic [31:0] ADDR_KCTRL = 32'hFFFFF084;
  localparam logic [31:0] ADDR_SDATA = 32'hFFFFF090;
  localparam logic [31:0] ADDR_SCTRL = 32'hFFFFF094;

  localparam int unsigned RDY_BIT = 0;
  localparam int unsigned OVR_BIT = 2;
  localparam int unsigned IE_BIT  = 4;

  typedef struct packed {
    logic ie;
    logic ovr;
    logic rdy;
  } ctrl_t;

  function automatic logic [31:0] ctrl_word(ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[RDY_BIT] = c.rdy;
    w[OVR_BIT] = c.ovr;
    w[IE_BIT]  = c.ie;
    return w;
  endfunction

  // Capture is applied last so a new event beats a same-cycle clear.
  function automatic ctrl_t ctrl_next(
    ctrl_t c,
    logic  cap,
    logic  clr,
    logic  wr,
    logic  wr_ie,
    logic  wr_ovr
  );
    ctrl_t n;
    n = c;
    if (wr) begin
      n.ie = wr_ie;
      if (!wr_ovr) n.ovr = 1'b0;
    end
    if (clr) n.rdy = 1'b0;
    if (cap) begin
      n.rdy = 1'b1;
      n.ovr = n.ovr | c.rdy;
    end
    return n;
  endfunction

endpackage

// File: rtl/key_sw_device_if.sv
// CPU-side register bus for the KEY/SW device.
interface key_sw_device_if;
  logic [31:0] abus;
  logic        rden;
  logic        wren;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        sel;

  modport master (
    output abus, rden, wren, wdata,
    input  rdata, sel
  );

  modport slave (
    input  abus, rden, wren, wdata,
    output rdata, sel
  );
endinterface

// File: rtl/key_sw_device_sw_debounce.sv
// Two-flop synchronizer plus stability counter for slide switches.
module sw_debounce #(
  parameter int W        = 10,
  parameter int DEBOUNCE = 500000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         stable
);

  localparam int CW = $clog2(DEBOUNCE);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic [W-1:0]  s1;
  logic [W-1:0]  s2;
  logic [CW-1:0] cnt;

  // Counter saturates once the value has held long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= '0;
      s2  <= '0;
      cnt <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s1 != s2)
        cnt <= '0;
      else if (cnt != LAST)
        cnt <= cnt + 1'b1;
    end
  end

  assign dout   = s2;
  assign stable = (cnt == LAST);

endmodule

// File: rtl/key_sw_device.sv
// Memory-mapped pushbutton and slide-switch input device.
module key_sw_device
  import key_sw_device_pkg::*;
#(
  parameter logic [31:0] ADDRKDATA = ADDR_KDATA,
  parameter logic [31:0] ADDRKCTRL = ADDR_KCTRL,
  parameter logic [31:0] ADDRSDATA = ADDR_SDATA,
  parameter logic [31:0] ADDRSCTRL = ADDR_SCTRL,
  parameter int          DEBOUNCE  = 500000
) (
  input  logic                  clk,
  input  logic                  RESET_N,
  key_sw_device_if.slave        bus,
  input  logic [3:0]            KEY,
  input  logic [9:0]            SW,
  output logic                  intr
);

  logic [3:0] k_s1;
  logic [3:0] k_s2;
  logic [3:0] kdata;
  logic [9:0] sdata;
  logic [9:0] sw_val;
  logic       sw_stable;
  ctrl_t      kctrl;
  ctrl_t      sctrl;

  logic hit_kd, hit_kc, hit_sd, hit_sc;
  logic k_cap, s_cap;
  logic [31:0] rdata_c;
  logic        sel_c;

  sw_debounce #(
    .W        (10),
    .DEBOUNCE (DEBOUNCE)
  ) u_sw_debounce (
    .clk    (clk),
    .rst_n  (RESET_N),
    .din    (SW),
    .dout   (sw_val),
    .stable (sw_stable)
  );

  assign hit_kd = (bus.abus == ADDRKDATA);
  assign hit_kc = (bus.abus == ADDRKCTRL);
  assign hit_sd = (bus.abus == ADDRSDATA);
  assign hit_sc = (bus.abus == ADDRSCTRL);

  assign k_cap = ((~k_s2) != kdata);
  assign s_cap = sw_stable && (sw_val != sdata);

  // Buttons are active-low; released state keeps synchronizers high.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      k_s1  <= 4'hF;
      k_s2  <= 4'hF;
      kdata <= '0;
      sdata <= '0;
      kctrl <= '0;
      sctrl <= '0;
    end else begin
      k_s1 <= KEY;
      k_s2 <= k_s1;
      if (k_cap) kdata <= ~k_s2;
      if (s_cap) sdata <= sw_val;
      kctrl <= ctrl_next(kctrl, k_cap,
                         bus.rden & hit_kd,
                         bus.wren & hit_kc,
                         bus.wdata[IE_BIT],
                         bus.wdata[OVR_BIT]);
      sctrl <= ctrl_next(sctrl, s_cap,
                         bus.rden & hit_sd,
                         bus.wren & hit_sc,
                         bus.wdata[IE_BIT],
                         bus.wdata[OVR_BIT]);
    end
  end

  always_comb begin
    rdata_c = '0;
    sel_c   = 1'b0;
    unique case (1'b1)
      hit_kd: begin
        rdata_c = {28'b0, kdata};
        sel_c   = 1'b1;
      end
      hit_kc: begin
        rdata_c = ctrl_word(kctrl);
        sel_c   = 1'b1;
      end
      hit_sd: begin
        rdata_c = {22'b0, sdata};
        sel_c   = 1'b1;
      end
      hit_sc: begin
        rdata_c = ctrl_word(sctrl);
        sel_c   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.rdata = rdata_c;
  assign bus.sel   = sel_c;

  assign intr = (kctrl.rdy & kctrl.ie)
              | (sctrl.rdy & sctrl.ie);

endmodule

// File: tb/tb_key_sw_device.sv
// Directed and randomized bench for key_sw_device.
module tb_key_sw_device;
  import key_sw_device_pkg::*;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic [9:0] sw;
  logic       intr;

  int total = 0;
  int bad   = 0;

  key_sw_device_if bus();

  key_sw_device #(.DEBOUNCE(D)) dut (
    .clk     (clk),
    .RESET_N (rst_n),
    .bus     (bus),
    .KEY     (key),
    .SW      (sw),
    .intr    (intr)
  );

  always #5 clk = ~clk;

  logic [3:0] m_kdata;
  logic [9:0] m_sdata;
  logic m_krdy, m_kovr, m_kie;
  logic m_srdy, m_sovr, m_sie;
  logic [3:0] kq[$];
  logic [9:0] sq[$];

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_kdata = '0; m_sdata = '0;
    m_krdy = 0; m_kovr = 0; m_kie = 0;
    m_srdy = 0; m_sovr = 0; m_sie = 0;
    kq.delete(); sq.delete();
    repeat (2) kq.push_back(4'hF);
    repeat (D + 1) sq.push_back(10'h0);
  endtask

  function automatic logic [31:0] m_read(logic [31:0] a);
    if (a == ADDR_KDATA) return {28'b0, m_kdata};
    if (a == ADDR_KCTRL)
      return {27'b0, m_kie, 1'b0, m_kovr, 1'b0, m_krdy};
    if (a == ADDR_SDATA) return {22'b0, m_sdata};
    if (a == ADDR_SCTRL)
      return {27'b0, m_sie, 1'b0, m_sovr, 1'b0, m_srdy};
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_sel(logic [31:0] a);
    return {31'b0, a == ADDR_KDATA || a == ADDR_KCTRL ||
                   a == ADDR_SDATA || a == ADDR_SCTRL};
  endfunction

  function automatic logic [31:0] m_intr();
    return {31'b0, (m_krdy & m_kie) | (m_srdy & m_sie)};
  endfunction

  // Pins seen two edges ago are what the device acts on now.
  task automatic m_edge();
    logic [3:0] kv;
    logic [9:0] sv;
    logic st, kcap, scap, k0, s0, rk, rs, wk, ws;
    kv = ~kq[1];
    sv = sq[1];
    st = 1'b1;
    for (int i = 2; i <= D; i++)
      if (sq[i] != sv) st = 1'b0;
    kcap = (kv != m_kdata);
    scap = st && (sv != m_sdata);
    rk = bus.rden && bus.abus == ADDR_KDATA;
    rs = bus.rden && bus.abus == ADDR_SDATA;
    wk = bus.wren && bus.abus == ADDR_KCTRL;
    ws = bus.wren && bus.abus == ADDR_SCTRL;
    k0 = m_krdy; s0 = m_srdy;
    if (wk) begin
      m_kie = bus.wdata[4];
      if (!bus.wdata[2]) m_kovr = 0;
    end
    if (ws) begin
      m_sie = bus.wdata[4];
      if (!bus.wdata[2]) m_sovr = 0;
    end
    if (rk) m_krdy = 0;
    if (rs) m_srdy = 0;
    if (kcap) begin
      m_kdata = kv; m_krdy = 1;
      if (k0) m_kovr = 1;
    end
    if (scap) begin
      m_sdata = sv; m_srdy = 1;
      if (s0) m_sovr = 1;
    end
    kq.push_front(key); void'(kq.pop_back());
    sq.push_front(sw);  void'(sq.pop_back());
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_edge();
    @(negedge clk);
  endtask

  task automatic peek(string tag, logic [31:0] a);
    bus.rden = 0; bus.wren = 0; bus.abus = a;
    #1 check(tag, bus.rdata, m_read(a));
  endtask

  task automatic peek_all(string tag);
    peek({tag, ".kd"}, ADDR_KDATA);
    peek({tag, ".kc"}, ADDR_KCTRL);
    peek({tag, ".sd"}, ADDR_SDATA);
    peek({tag, ".sc"}, ADDR_SCTRL);
    check({tag, ".intr"}, {31'b0, intr}, m_intr());
  endtask

  task automatic rd(string tag, logic [31:0] a);
    bus.abus = a; bus.rden = 1; bus.wren = 0;
    #1 check(tag, bus.rdata, m_read(a));
    cyc();
    bus.rden = 0;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    bus.abus = a; bus.wren = 1; bus.rden = 0;
    bus.wdata = d;
    cyc();
    bus.wren = 0;
  endtask

  initial begin
    logic [31:0] addrs [6];
    int sw_hold;
    logic [9:0] tgt;
    addrs = '{ADDR_KDATA, ADDR_KCTRL, ADDR_SDATA,
              ADDR_SCTRL, 32'hFFFFF088, 32'h0};
    bus.abus = '0; bus.rden = 0; bus.wren = 0;
    bus.wdata = '0;
    rst_n = 0; key = 4'hF; sw = '0;
    m_reset();
    repeat (3) cyc();
    peek_all("rst");
    check("rst.intr0", {31'b0, intr}, 32'h0);
    rst_n = 1;
    cyc();

    // Single press
    key = 4'hE;
    repeat (3) cyc();
    peek("k1.ctrl", ADDR_KCTRL);
    check("k1.ctrl1", bus.rdata, 32'h1);
    rd("k1.data", ADDR_KDATA);
    peek("k1.ctrl0", ADDR_KCTRL);
    check("k1.ctrl0c", bus.rdata, 32'h0);

    // Two presses without a read set overrun
    key = 4'hF;
    repeat (3) cyc();
    rd("k2.clr", ADDR_KDATA);
    key = 4'hE;
    repeat (3) cyc();
    key = 4'hC;
    repeat (3) cyc();
    peek("k2.ovr", ADDR_KCTRL);
    check("k2.ovr5", bus.rdata, 32'h5);
    wr(ADDR_KCTRL, 32'h0);
    peek("k2.wclr", ADDR_KCTRL);
    check("k2.wclr1", bus.rdata, 32'h1);
    check("k2.data3", m_read(ADDR_KDATA), 32'h3);

    // Capture coincides with a data read
    rd("k3.clr", ADDR_KDATA);
    key = 4'hA;
    repeat (2) cyc();
    rd("k3.race", ADDR_KDATA);
    peek("k3.ctrl", ADDR_KCTRL);
    check("k3.ctrl1", bus.rdata, 32'h1);
    peek("k3.data", ADDR_KDATA);
    check("k3.data5", bus.rdata, 32'h5);

    // Bouncing switch, then a long hold
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 0) sw = sw ^ 10'h001;
      cyc();
      peek("sw.bounce", ADDR_SDATA);
      check("sw.bounce0", bus.rdata, 32'h0);
    end
    sw = 10'h3FF;
    for (int e = 1; e <= 10; e++) begin
      cyc();
      peek("sw.hold", ADDR_SDATA);
      check("sw.holdc", bus.rdata,
            (e < 10) ? 32'h0 : 32'h3FF);
    end

    // Interrupt on switch acceptance
    rd("si.clr", ADDR_SDATA);
    wr(ADDR_SCTRL, 32'h10);
    sw = 10'h155;
    for (int e = 1; e <= D + 2; e++) begin
      cyc();
      check("si.intr", {31'b0, intr}, m_intr());
      check("si.intrc", {31'b0, intr},
            (e < D + 2) ? 32'h0 : 32'h1);
    end
    rd("si.data", ADDR_SDATA);
    check("si.fall", {31'b0, intr}, 32'h0);

    // Randomized traffic against the model
    sw_hold = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 19) == 0) key = 4'($urandom);
      if (sw_hold == 0) begin
        sw = 10'($urandom);
        sw_hold = $urandom_range(1, 14);
      end else begin
        sw_hold--;
      end
      bus.abus  = addrs[$urandom_range(0, 5)];
      bus.rden  = ($urandom_range(0, 3) == 0);
      bus.wren  = ($urandom_range(0, 3) == 0);
      bus.wdata = $urandom;
      #1;
      check("rnd.rdata", bus.rdata, m_read(bus.abus));
      check("rnd.sel", {31'b0, bus.sel}, m_sel(bus.abus));
      check("rnd.intr", {31'b0, intr}, m_intr());
      cyc();
    end
    bus.rden = 0; bus.wren = 0;

    // Unmapped hole and reset during debounce
    bus.abus = 32'hFFFFF088; bus.rden = 1;
    #1;
    check("hole.sel", {31'b0, bus.sel}, 32'h0);
    check("hole.rdata", bus.rdata, 32'h0);
    cyc();
    bus.rden = 0;
    key = 4'hF;
    repeat (3) cyc();
    tgt = (sw == 10'h2AA) ? 10'h155 : 10'h2AA;
    sw = tgt;
    repeat (4) cyc();
    rst_n = 0;
    m_reset();
    repeat (2) cyc();
    peek_all("rst2");
    for (int i = 0; i < 4; i++) begin
      peek("rst2.zero", addrs[i]);
      check("rst2.zeroc", bus.rdata, 32'h0);
    end
    rst_n = 1;
    for (int e = 1; e <= D + 2; e++) begin
      cyc();
      peek("rel.sc", ADDR_SCTRL);
      check("rel.scc", bus.rdata,
            (e < D + 2) ? 32'h0 : 32'h1);
    end
    peek("rel.sd", ADDR_SDATA);
    check("rel.sdc", bus.rdata, {22'b0, tgt});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
